// File: rtl/text_tile_renderer.sv
// 80x30 text-mode tile renderer: char RAM, 3-stage pixel pipeline, screen clear.
// Ports: clk/reset, p_tick+x/y/video_on/syncs in, char write port, clr_start/busy,
//   cursor_col/row, font_addr/font_data to an external ROM, rgb/hsync_out/vsync_out.
// Optional: define CURSOR_BLINK_EN to invert the cursor cell every 16 frames.
module text_tile_renderer #(
  parameter logic [7:0] FG_COLOR = 8'b00011100,
  parameter logic [7:0] BG_COLOR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        wr_en,
  input  logic [6:0]  wr_col,
  input  logic [4:0]  wr_row,
  input  logic [6:0]  wr_char,
  input  logic        clr_start,
  output logic        busy,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [7:0]  rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int         CELLS = 2400;
  localparam logic [6:0] BLANK = 7'h20;

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  function automatic logic [11:0] cell_addr(
    input logic [6:0] col,
    input logic [4:0] row
  );
    return ({7'd0, row} << 6) + ({7'd0, row} << 4)
         + {5'd0, col};
  endfunction

  logic [6:0] char_mem [CELLS];

  state_e      state_q, state_d;
  logic [11:0] clr_addr_q, clr_addr_d;
  logic        busy_q, busy_d;

  logic        mem_we;
  logic [11:0] mem_waddr;
  logic [6:0]  mem_wdata;

  logic [6:0]  rd_col;
  logic [4:0]  rd_row;
  logic [11:0] rd_addr;
  logic [6:0]  rd_char;

  logic [6:0] a_char_q, a_char_d;
  logic [2:0] a_xbit_q, a_xbit_d;
  logic [3:0] a_grow_q, a_grow_d;
  logic       a_vid_q, a_vid_d;
  logic       a_hs_q, a_hs_d;
  logic       a_vs_q, a_vs_d;

  logic       b_bit_q, b_bit_d;
  logic       b_vid_q, b_vid_d;
  logic       b_hs_q, b_hs_d;
  logic       b_vs_q, b_vs_d;

  logic [7:0] rgb_q, rgb_d;
  logic       hs_out_q, hs_out_d;
  logic       vs_out_q, vs_out_d;

  logic       font_bit;

`ifdef CURSOR_BLINK_EN
  logic       a_cur_q, a_cur_d;
  logic [4:0] frame_q, frame_d;
  logic       vs_prev_q, vs_prev_d;
  logic       unused_y;
  assign unused_y = y[9];
`else
  logic unused_in;
  assign unused_in = ^{cursor_col, cursor_row, y[9]};
`endif

  // Clear FSM
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy_d     = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
          busy_d     = 1'b1;
        end
      end
      S_CLEAR: begin
        if (clr_addr_q == 12'(CELLS - 1)) begin
          state_d    = S_IDLE;
          clr_addr_d = '0;
          busy_d     = 1'b0;
        end else begin
          clr_addr_d = clr_addr_q + 12'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      clr_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
    end
  end

  // Clear owns the write port; host writes during a clear are dropped.
  // Reset gates the write so an aborted clear never touches the next cell.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cell_addr(wr_col, wr_row);
    mem_wdata = wr_char;
    if (!reset) begin
      if (state_q == S_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = BLANK;
      end else if (wr_en && !busy_q &&
                   wr_col < 7'd80 && wr_row < 5'd30) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) char_mem[mem_waddr] <= mem_wdata;
  end

  // Read is combinational into stage A, so a same-edge write
  // is seen by the next read only (old data returned).
  assign rd_col  = x[9:3];
  assign rd_row  = y[8:4];
  assign rd_addr = cell_addr(rd_col, rd_row);
  assign rd_char = (rd_addr < 12'(CELLS)) ? char_mem[rd_addr] : 7'h00;

  assign font_bit = font_data[~a_xbit_q];

  always_comb begin
    a_char_d = a_char_q;
    a_xbit_d = a_xbit_q;
    a_grow_d = a_grow_q;
    a_vid_d  = a_vid_q;
    a_hs_d   = a_hs_q;
    a_vs_d   = a_vs_q;
    b_bit_d  = b_bit_q;
    b_vid_d  = b_vid_q;
    b_hs_d   = b_hs_q;
    b_vs_d   = b_vs_q;
    rgb_d    = rgb_q;
    hs_out_d = hs_out_q;
    vs_out_d = vs_out_q;
`ifdef CURSOR_BLINK_EN
    a_cur_d   = a_cur_q;
    vs_prev_d = vsync_in;
    frame_d   = frame_q + {4'd0, vs_prev_q & ~vsync_in};
`endif
    if (p_tick) begin
      a_char_d = rd_char;
      a_xbit_d = x[2:0];
      a_grow_d = y[3:0];
      a_vid_d  = video_on;
      a_hs_d   = hsync_in;
      a_vs_d   = vsync_in;
`ifdef CURSOR_BLINK_EN
      a_cur_d  = (rd_col == cursor_col) && (rd_row == cursor_row);
      b_bit_d  = font_bit ^ (frame_q[4] & a_cur_q);
`else
      b_bit_d  = font_bit;
`endif
      b_vid_d  = a_vid_q;
      b_hs_d   = a_hs_q;
      b_vs_d   = a_vs_q;
      if (!b_vid_q)     rgb_d = 8'h00;
      else if (b_bit_q) rgb_d = FG_COLOR;
      else              rgb_d = BG_COLOR;
      hs_out_d = b_hs_q;
      vs_out_d = b_vs_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_char_q <= '0;
      a_xbit_q <= '0;
      a_grow_q <= '0;
      a_vid_q  <= 1'b0;
      a_hs_q   <= 1'b0;
      a_vs_q   <= 1'b0;
      b_bit_q  <= 1'b0;
      b_vid_q  <= 1'b0;
      b_hs_q   <= 1'b0;
      b_vs_q   <= 1'b0;
      rgb_q    <= '0;
      hs_out_q <= 1'b0;
      vs_out_q <= 1'b0;
`ifdef CURSOR_BLINK_EN
      a_cur_q   <= 1'b0;
      frame_q   <= '0;
      vs_prev_q <= 1'b0;
`endif
    end else begin
      a_char_q <= a_char_d;
      a_xbit_q <= a_xbit_d;
      a_grow_q <= a_grow_d;
      a_vid_q  <= a_vid_d;
      a_hs_q   <= a_hs_d;
      a_vs_q   <= a_vs_d;
      b_bit_q  <= b_bit_d;
      b_vid_q  <= b_vid_d;
      b_hs_q   <= b_hs_d;
      b_vs_q   <= b_vs_d;
      rgb_q    <= rgb_d;
      hs_out_q <= hs_out_d;
      vs_out_q <= vs_out_d;
`ifdef CURSOR_BLINK_EN
      a_cur_q   <= a_cur_d;
      frame_q   <= frame_d;
      vs_prev_q <= vs_prev_d;
`endif
    end
  end

  assign font_addr = {a_char_q, a_grow_q};
  assign busy      = busy_q;
  assign rgb       = rgb_q;
  assign hsync_out = hs_out_q;
  assign vsync_out = vs_out_q;

endmodule

// File: tb/tb_text_tile_renderer.sv
// Directed bench for text_tile_renderer (default build).
// Font ROM model: glyph row 1 = {0,char}; 'A' row 0 = 8'h80; else 0.
module tb_text_tile_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        hsync_in;
  logic        vsync_in;
  logic        wr_en;
  logic [6:0]  wr_col;
  logic [4:0]  wr_row;
  logic [6:0]  wr_char;
  logic        clr_start;
  logic        busy;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [10:0] font_addr;
  logic [7:0]  font_data = 8'h00;
  logic [7:0]  rgb;
  logic        hsync_out;
  logic        vsync_out;

  localparam logic [7:0] FG = 8'h1C;

  int checks = 0;
  int errors = 0;
  logic [6:0] mdl [2400];

  text_tile_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .p_tick     (p_tick),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .wr_en      (wr_en),
    .wr_col     (wr_col),
    .wr_row     (wr_row),
    .wr_char    (wr_char),
    .clr_start  (clr_start),
    .busy       (busy),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [10:0] a);
    if (a[3:0] == 4'd1) return {1'b0, a[10:4]};
    if (a[3:0] == 4'd0 && a[10:4] == 7'h41) return 8'h80;
    return 8'h00;
  endfunction

  always @(posedge clk) font_data <= rom(font_addr);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    p_tick = 1'b1;
    @(posedge clk); #1;
    p_tick = 1'b0;
    wr_en  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input int c, input int r, input logic [6:0] ch);
    wr_en   = 1'b1;
    wr_col  = 7'(c);
    wr_row  = 5'(r);
    wr_char = ch;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (c < 80 && r < 30) mdl[r*80 + c] = ch;
  endtask

  // Streams glyph row 1 of each cell and rebuilds the char from rgb.
  // coll: host write to the first cell on the same edge as its pixel 1.
  task automatic read_cells(input int first, input int count,
                            input bit coll);
    logic [7:0] ob[$];
    logic [7:0] b, e;
    int n, a;
    n = count*8 + 2;
    for (int t = 0; t < n; t++) begin
      if (t < count*8) begin
        a = first + t/8;
        x = 10'((a % 80)*8 + t % 8);
        y = 10'((a / 80)*16 + 1);
        video_on = 1'b1;
        if (coll && t == 1) begin
          wr_en   = 1'b1;
          wr_col  = 7'(a % 80);
          wr_row  = 5'(a / 80);
          wr_char = 7'h55;
        end
      end else begin
        video_on = 1'b0;
        x = '0;
        y = '0;
      end
      tick();
      if (t >= 2) ob.push_back(rgb);
    end
    for (int i = 0; i < count; i++) begin
      for (int j = 0; j < 8; j++) b[7-j] = (ob[i*8+j] == FG);
      e = {1'b0, mdl[first+i]};
      if (coll) e = {1'b0, mdl[first][6], 6'h15};
      chk("cell", 32'(b), 32'(e));
    end
    if (coll) mdl[first] = 7'h55;
  endtask

  initial begin
    int n;
    reset = 1'b1; p_tick = 0; video_on = 0; x = 0; y = 0;
    hsync_in = 0; vsync_in = 0; wr_en = 0; wr_col = 0; wr_row = 0;
    wr_char = 0; clr_start = 0; cursor_col = 0; cursor_row = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_hs", 32'(hsync_out), 32'h0);
    chk("rst_vs", 32'(vsync_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_faddr", 32'(font_addr), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // full clear; host write and second clr_start while busy
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    n = 0;
    while (busy && n < 3000) begin
      n++;
      if (n == 100) begin
        wr_en = 1'b1; wr_col = 7'd5; wr_row = 5'd5; wr_char = 7'h5A;
      end
      if (n == 101) wr_en = 1'b0;
      if (n == 200) clr_start = 1'b1;
      if (n == 201) clr_start = 1'b0;
      @(posedge clk); #1;
    end
    chk("busy_len", 32'(n), 32'd2400);
    for (int i = 0; i < 2400; i++) mdl[i] = 7'h20;
    read_cells(0, 2400, 1'b0);

    // 'A' at (0,0): lit leftmost pixel, unlit next pixel
    wr(0, 0, 7'h41);
    x = 0; y = 0; video_on = 1'b1;
    tick();
    chk("font_addr", 32'(font_addr), 32'h410);
    x = 1;
    tick();
    video_on = 1'b0; x = 0;
    tick();
    chk("pix00", 32'(rgb), 32'h1C);
    tick();
    chk("pix10", 32'(rgb), 32'h00);

    // out-of-range writes ignored, last cell reachable
    wr(80, 0, 7'h42);
    wr(0, 30, 7'h43);
    wr(127, 0, 7'h45);
    wr(80, 29, 7'h46);
    wr(79, 29, 7'h44);
    read_cells(80, 1, 1'b0);
    read_cells(127, 1, 1'b0);
    read_cells(2399, 1, 1'b0);
    read_cells(0, 1, 1'b0);

    // read and write of the same cell on the same edge
    read_cells(3, 1, 1'b1);
    read_cells(3, 1, 1'b0);

    // blanked video, sync latency and hold without p_tick
    x = 0; y = 0; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    tick();
    chk("hs_t1", 32'(hsync_out), 32'h0);
    hsync_in = 1'b0; vsync_in = 1'b0;
    tick();
    chk("hs_t2", 32'(hsync_out), 32'h0);
    tick();
    chk("hs_t3", 32'(hsync_out), 32'h1);
    chk("vs_t3", 32'(vsync_out), 32'h1);
    chk("blank_rgb", 32'(rgb), 32'h0);
    x = 10'd1; video_on = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("hs_hold", 32'(hsync_out), 32'h1);
    video_on = 1'b0;
    tick();
    chk("hs_t4", 32'(hsync_out), 32'h0);

    // reset aborts a clear after 1000 cells
    wr(39, 12, 7'h6A);
    wr(40, 12, 7'h6B);
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_rgb", 32'(rgb), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 1000; i++) mdl[i] = 7'h20;
    read_cells(998, 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
